// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: branch kinds, ARM condition codes,
// resolver FSM states and the bit positions inside the {N,Z,C,V} nibble.
package branch_resolver_pkg;

  typedef enum logic [1:0] {
    BR_B     = 2'd0,
    BR_CBZ   = 2'd1,
    BR_CBNZ  = 2'd2,
    BR_BCOND = 2'd3
  } br_type_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_HS = 4'd2,
    COND_LO = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_FLUSHING = 1'b1
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// cond_eval: purely combinational ARM condition-code evaluation on {N,Z,C,V}.
module cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       met
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition code against the selected flags.
  always_comb begin
    met = 1'b0;
    case (cond_e'(cond))
      COND_EQ: met = z;
      COND_NE: met = !z;
      COND_HS: met = c;
      COND_LO: met = !c;
      COND_MI: met = n;
      COND_PL: met = !n;
      COND_VS: met = v;
      COND_VC: met = !v;
      COND_HI: met = c && !z;
      COND_LS: met = !c || z;
      COND_GE: met = (n == v);
      COND_LT: met = (n != v);
      COND_GT: met = !z && (n == v);
      COND_LE: met = z || (n != v);
      default: met = 1'b1;  // AL and NV are both unconditional
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves ID-stage branches, issues a registered one-cycle
// redirect and squashes IF/ID for FLUSH_CYCLES cycles after a taken branch.
// Holds the architectural NZCV register.
// Optional feature: define FLAG_BYPASS_EN to let a B.cond use the flags the
// EX stage is producing in the same cycle instead of stalling for them.
//
// Handshake: a branch is accepted when br_valid=1 in IDLE with stall=0; the
// redirect is then presented as redirect_valid=1 for exactly one cycle with
// redirect_pc valid that cycle. There is no ready; the fetch side must accept.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        ex_set_flags,
  input  logic [3:0]  ex_flags,
  input  logic        br_valid,
  input  logic [1:0]  br_type,
  input  logic [3:0]  br_cond,
  input  logic        reg_zero,
  input  logic [63:0] br_target,
  output logic        stall,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        flush,
  output logic [3:0]  flags_q,
  output state_e      dbg_state
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flag_setter;
  logic        idle;
  logic [3:0]  eval_flags;
  logic        cond_met;
  logic        br_taken;
  logic        stall_c;
  logic        take;

  assign flag_setter = ex_valid && ex_set_flags;
  assign idle        = (state_q == ST_IDLE);

  // Pick the flags a B.cond sees and decide whether it must wait for them.
  always_comb begin
`ifdef FLAG_BYPASS_EN
    eval_flags = flag_setter ? ex_flags : flags_q;
    stall_c    = 1'b0;
`else
    // Once the setter has written flags_q it has left EX, so the stall only
    // recurs if a different flag-setter is sitting in EX next cycle.
    eval_flags = flags_q;
    stall_c    = idle && br_valid && (br_type_e'(br_type) == BR_BCOND)
                 && flag_setter;
`endif
  end

  cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (br_cond),
    .met   (cond_met)
  );

  // Branch outcome by kind.
  always_comb begin
    br_taken = 1'b0;
    case (br_type_e'(br_type))
      BR_B:     br_taken = 1'b1;
      BR_CBZ:   br_taken = reg_zero;
      BR_CBNZ:  br_taken = !reg_zero;
      BR_BCOND: br_taken = cond_met;
      default:  br_taken = 1'b0;
    endcase
  end

  // Next-state logic: IDLE accepts branches, FLUSHING counts down and ignores them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_valid && !stall_c && br_taken) begin
          take    = 1'b1;
          state_d = ST_FLUSHING;
          cnt_d   = FLUSH_LOAD;
        end
      end
      ST_FLUSHING: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, counter, redirect and flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 3'd0;
      flags_q        <= 4'b0000;
      redirect_valid <= 1'b0;
      redirect_pc    <= 64'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      redirect_valid <= take;
      if (take) begin
        redirect_pc <= br_target;
      end
      if (flag_setter) begin
        flags_q <= ex_flags;
      end
    end
  end

  assign flush     = (state_q == ST_FLUSHING);
  assign stall     = stall_c;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios followed by random traffic,
// all outputs compared every cycle against a cycle-level behavioural model.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int FLUSH = 2;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_set_flags;
  logic [3:0]  ex_flags;
  logic        br_valid;
  logic [1:0]  br_type;
  logic [3:0]  br_cond;
  logic        reg_zero;
  logic [63:0] br_target;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic [3:0]  flags_q;
  state_e      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: flags register, remaining flush cycles, pending redirect.
  logic [3:0]  m_flags;
  int          m_flush_left;
  bit          m_redir;
  logic [63:0] m_pc;
  bit          model_live = 1'b0;

  branch_resolver #(.FLUSH_CYCLES(FLUSH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ex_valid       (ex_valid),
    .ex_set_flags   (ex_set_flags),
    .ex_flags       (ex_flags),
    .br_valid       (br_valid),
    .br_type        (br_type),
    .br_cond        (br_cond),
    .reg_zero       (reg_zero),
    .br_target      (br_target),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .flags_q        (flags_q),
    .dbg_state      (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input logic [3:0] f, input int code);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit ref_stall();
`ifdef FLAG_BYPASS_EN
    return 1'b0;
`else
    return (m_flush_left == 0) && br_valid && (br_type == 2'd3) && ex_valid && ex_set_flags;
`endif
  endfunction

  function automatic bit ref_taken();
    logic [3:0] f;
    f = m_flags;
`ifdef FLAG_BYPASS_EN
    if (ex_valid && ex_set_flags) f = ex_flags;
`endif
    case (br_type)
      2'd0:    return 1'b1;
      2'd1:    return reg_zero;
      2'd2:    return !reg_zero;
      default: return ref_cond(f, int'(br_cond));
    endcase
  endfunction

  task automatic compare_outputs();
    if (model_live) begin
      check("m_flags_q", 64'(flags_q), 64'(m_flags));
      check("m_flush", 64'(flush), 64'(m_flush_left > 0));
      check("m_redirect_valid", 64'(redirect_valid), 64'(m_redir));
      check("m_redirect_pc", redirect_pc, m_pc);
      check("m_stall", 64'(stall), 64'(ref_stall()));
      check("m_state", 64'(dbg_state), (m_flush_left > 0) ? 64'(ST_FLUSHING) : 64'(ST_IDLE));
    end
  endtask

  task automatic model_update();
    bit tk;
    if (!reset_n) begin
      m_flags = 4'd0; m_flush_left = 0; m_redir = 1'b0; m_pc = 64'd0;
      model_live = 1'b1;
    end else if (model_live) begin
      tk = (m_flush_left == 0) && br_valid && !ref_stall() && ref_taken();
      m_redir = tk;
      if (tk) begin
        m_pc = br_target;
        m_flush_left = FLUSH;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end
      if (ex_valid && ex_set_flags) m_flags = ex_flags;
    end
  endtask

  // One clock: check current outputs, let the edge happen, advance the model.
  task automatic tick();
    #1;
    compare_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_set_flags = 1'b0; ex_flags = 4'd0;
    br_valid = 1'b0; br_type = 2'd0; br_cond = 4'd0;
    reg_zero = 1'b0; br_target = 64'd0;
  endtask

  task automatic drive_branch(input logic [1:0] t, input logic [3:0] c,
                              input logic rz, input logic [63:0] tgt);
    br_valid = 1'b1; br_type = t; br_cond = c; reg_zero = rz; br_target = tgt;
  endtask

  task automatic drive_flags(input logic [3:0] f);
    ex_valid = 1'b1; ex_set_flags = 1'b1; ex_flags = f;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    tick();
    tick();

    // Out of reset, nothing driven.
    reset_n = 1'b1;
    tick();
    check("rst_flags_q", 64'(flags_q), 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'h0);

    // Unconditional B, then a branch during the flush.
    drive_branch(2'd0, 4'd0, 1'b0, 64'h1000);
    tick();
    br_valid = 1'b0;
    check("b_redirect_valid", 64'(redirect_valid), 64'h1);
    check("b_redirect_pc", redirect_pc, 64'h1000);
    check("b_flush1", 64'(flush), 64'h1);
    drive_branch(2'd0, 4'd0, 1'b0, 64'h2000);
    #1 check("b_no_stall_in_flush", 64'(stall), 64'h0);
    tick();
    br_valid = 1'b0;
    check("b_flush2", 64'(flush), 64'h1);
    check("b_ignored_rv", 64'(redirect_valid), 64'h0);
    tick();
    check("b_flush_done", 64'(flush), 64'h0);
    check("b_ignored_pc", redirect_pc, 64'h1000);
    check("b_ignored_rv2", 64'(redirect_valid), 64'h0);

    // CBZ taken, CBNZ not taken.
    drive_branch(2'd1, 4'd0, 1'b1, 64'h3000);
    tick();
    br_valid = 1'b0;
    check("cbz_redirect", 64'(redirect_valid), 64'h1);
    check("cbz_pc", redirect_pc, 64'h3000);
    tick(); tick();
    drive_branch(2'd2, 4'd0, 1'b1, 64'h3100);
    tick();
    br_valid = 1'b0;
    check("cbnz_no_redirect", 64'(redirect_valid), 64'h0);
    check("cbnz_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("cbnz_pc_hold", redirect_pc, 64'h3000);

    // B.cond on flags_q = Z set.
    drive_flags(4'b0100);
    tick();
    idle_inputs();
    check("flags_load", 64'(flags_q), 64'h4);
    drive_branch(2'd3, 4'd1, 1'b0, 64'h3800);
    tick();
    br_valid = 1'b0;
    check("ne_not_taken", 64'(redirect_valid), 64'h0);
    drive_branch(2'd3, 4'd0, 1'b0, 64'h4000);
    tick();
    br_valid = 1'b0;
    check("eq_taken", 64'(redirect_valid), 64'h1);
    check("eq_pc", redirect_pc, 64'h4000);
    tick(); tick();
    drive_flags(4'b1000);
    tick();
    idle_inputs();
    drive_branch(2'd3, 4'd12, 1'b0, 64'h4800);
    tick();
    br_valid = 1'b0;
    check("gt_not_taken", 64'(redirect_valid), 64'h0);

    // Flag-setter in EX alongside a B.cond EQ.
    drive_flags(4'b0100);
    drive_branch(2'd3, 4'd0, 1'b0, 64'h5000);
    #1;
`ifdef FLAG_BYPASS_EN
    check("same_cycle_stall", 64'(stall), 64'h0);
    tick();
    idle_inputs();
    check("bypass_redirect", 64'(redirect_valid), 64'h1);
    check("bypass_pc", redirect_pc, 64'h5000);
`else
    check("same_cycle_stall", 64'(stall), 64'h1);
    tick();
    ex_valid = 1'b0; ex_set_flags = 1'b0;
    check("stall_no_redirect", 64'(redirect_valid), 64'h0);
    #1 check("stall_once", 64'(stall), 64'h0);
    tick();
    idle_inputs();
    check("stall_redirect", 64'(redirect_valid), 64'h1);
    check("stall_pc", redirect_pc, 64'h5000);
`endif
    tick(); tick();

    // Reset during the second flush cycle.
    drive_branch(2'd0, 4'd0, 1'b0, 64'h6000);
    tick();
    br_valid = 1'b0;
    tick();
    check("mid_flush_flush", 64'(flush), 64'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_abort_flush", 64'(flush), 64'h0);
    check("rst_abort_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_abort_flags", 64'(flags_q), 64'h0);
    check("rst_abort_rv", 64'(redirect_valid), 64'h0);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n      = ($urandom_range(0, 99) != 0);
      ex_valid     = $urandom_range(0, 1);
      ex_set_flags = ($urandom_range(0, 2) != 0);
      ex_flags     = 4'($urandom);
      br_valid     = ($urandom_range(0, 2) != 0);
      br_type      = 2'($urandom);
      br_cond      = 4'($urandom);
      reg_zero     = $urandom_range(0, 1);
      br_target    = {$urandom, $urandom};
      tick();
    end
    idle_inputs();
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning cycles of squash after a taken branch (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, meaning a synchronous, active-low reset sampled on the rising edge of clk.
REQ-004 SHALL have port ex_valid, input, 1, meaning the EX-stage instruction is valid.
REQ-005 SHALL have port ex_set_flags, input, 1, meaning the EX instruction writes NZCV.
REQ-006 SHALL have port ex_flags, input, 4, meaning the {N,Z,C,V} produced by the ALU and zero checker.
REQ-007 SHALL have port br_valid, input, 1, meaning a branch is present in ID.
REQ-008 SHALL have port br_type, input, 2, meaning 0=B, 1=CBZ, 2=CBNZ, 3=B.cond.
REQ-009 SHALL have port br_cond, input, 4, meaning the B.cond condition code.
REQ-010 SHALL have port reg_zero, input, 1, meaning the zero-checker result on the CBZ/CBNZ source register.
REQ-011 SHALL have port br_target, input, 64, meaning the branch target address.
REQ-012 SHALL have port stall, output, 1, meaning hold ID and IF this cycle.
REQ-013 SHALL have port redirect_valid, output, 1, meaning a registered one-cycle redirect request.
REQ-014 SHALL have port redirect_pc, output, 64, meaning the registered redirect address.
REQ-015 SHALL have port flush, output, 1, meaning squash IF/ID contents.
REQ-016 SHALL have port flags_q, output, 4, meaning the architectural NZCV register.

Function
REQ-017 SHALL load flags_q <= ex_flags at the clock edge when ex_valid && ex_set_flags; otherwise flags_q SHALL hold. Flag updates are honoured in every FSM state.
REQ-018 SHALL evaluate the branch as follows: B always taken; CBZ taken iff reg_zero; CBNZ taken iff !reg_zero; B.cond evaluated on the ARM codes (EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL and NV always).
REQ-019 SHALL use an FSM with states IDLE and FLUSHING plus a 3-bit down-counter.
REQ-020 In IDLE, a taken, non-stalled branch SHALL register redirect_valid=1 and redirect_pc=br_target at the next edge, enter FLUSHING, and load the counter with FLUSH_CYCLES.
REQ-021 flush SHALL be high exactly while in FLUSHING; the counter SHALL decrement each cycle; FLUSHING SHALL return to IDLE when the counter reaches 1.
REQ-022 redirect_valid SHALL be high for exactly one cycle, which is the first FLUSHING cycle.
REQ-023 In FLUSHING, br_valid SHALL be ignored: no evaluation, no redirect, and stall=0.
REQ-024 A not-taken branch SHALL produce no output change and the FSM SHALL stay in IDLE.
REQ-025 The latency from taken branch evaluation to redirect_valid SHALL be 1 cycle.
REQ-026 redirect_pc SHALL hold its last value when redirect_valid=0.
REQ-027 stall SHALL be combinational and high only under REQ-031.

Reset
REQ-028 While reset_n=0 at an edge, the block SHALL set state=IDLE, counter=0, flags_q=4'b0000, redirect_valid=0, redirect_pc=0, and flush=0.
REQ-029 A reset asserted mid-FLUSHING SHALL abort the flush and discard any pending redirect.

Configuration
REQ-030 With FLAG_BYPASS_EN defined, a B.cond in the same cycle as ex_valid && ex_set_flags SHALL evaluate on ex_flags, and stall SHALL be constantly 0.
REQ-031 Without FLAG_BYPASS_EN, that case SHALL raise stall for one cycle, with no evaluation that cycle; the B.cond SHALL be evaluated the next cycle on the updated flags_q. A stall SHALL NOT repeat for the same branch unless a new flag-setter is in EX.

Structure
REQ-032 A shared package SHALL hold the br_type enum, the condition-code enum, and the FSM state enum.
REQ-033 Combinational condition evaluation SHALL be a sub-module named cond_eval with ports (flags, cond, met).
REQ-034 Gate delays SHALL use the common delay constants.

Verification
REQ-035 Test: after reset release, with no inputs -> flags_q=0, flush=0, redirect_valid=0.
REQ-036 Test: br_valid, type B, target 64'h1000 -> next cycle redirect_valid=1, redirect_pc=64'h1000; flush high for 2 cycles; a branch during the flush is ignored.
REQ-037 Test: CBZ with reg_zero=1 -> redirect; CBNZ with reg_zero=1 -> no redirect, FSM stays IDLE.
REQ-038 Test: flags_q=4'b0100 then B.cond NE -> not taken; B.cond EQ -> taken; GT with N=1, V=0 -> not taken.
REQ-039 Test: same-cycle flag-setter with ex_flags Z=1 and B.cond EQ -> with macro, redirect next cycle; without macro, stall=1 for one cycle and redirect one cycle later.
REQ-040 Test: reset_n=0 in the second FLUSHING cycle -> next cycle flush=0, IDLE, flags_q=0.
